// File: rtl/asm_pass_sequencer.sv
// Two-pass assembler sequencer: walks the source-line buffer once for label
// collection (pass 0) and once for encoding (pass 1), one line per handshake.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   start_in              start request, honoured only in IDLE
//   num_lines_in          line count, sampled on accepted start (clamped)
//   line_valid_out        current line/pc/pass presented downstream
//   line_ready_in         downstream accepts current line
//   line_err_in           line error flag, sampled on valid && ready
//   line_addr_out, pc_out current line index and byte PC (line*4)
//   pass_out              0 = label pass, 1 = encode pass
//   busy_out, done_out    state != IDLE, one-cycle completion pulse
//   error_out             sticky error since last accepted start
//   err_line_out          line index of the first error since last start
//
// Build option: ASM_ERROR_HALT_EN - a line error ends the run immediately
// (straight to DONE); otherwise errors are only recorded.

module asm_pass_sequencer #(
    parameter  int NUMBER_LINES = 256,
    localparam int LINE_W       = $clog2(NUMBER_LINES),
    localparam int PC_W         = $clog2(NUMBER_LINES * 4)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [LINE_W:0]   num_lines_in,
    output logic              line_valid_out,
    input  logic              line_ready_in,
    input  logic              line_err_in,
    output logic [LINE_W-1:0] line_addr_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              pass_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out,
    output logic [LINE_W-1:0] err_line_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PASS0  = 3'd1;
    localparam logic [2:0] S_SWITCH = 3'd2;
    localparam logic [2:0] S_PASS1  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state;
    logic [LINE_W:0]   n_q;
    logic [LINE_W-1:0] line_q;
    logic              pass_q;
    logic              err_q;
    logic [LINE_W-1:0] err_line_q;

    logic [LINE_W:0]   n_clamp;
    logic              in_pass;
    logic              hs;
    logic              last_line;
    logic              hs_err;

    // Clamp keeps the PC inside the buffer range, so no wrap in a legal run.
    assign n_clamp = (num_lines_in > (LINE_W+1)'(NUMBER_LINES))
                   ? (LINE_W+1)'(NUMBER_LINES) : num_lines_in;

    assign in_pass   = (state == S_PASS0) || (state == S_PASS1);
    assign hs        = in_pass && line_ready_in;
    assign last_line = ({1'b0, line_q} == (n_q - 1'b1));
    assign hs_err    = hs && line_err_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            n_q        <= '0;
            line_q     <= '0;
            pass_q     <= 1'b0;
            err_q      <= 1'b0;
            err_line_q <= '0;
        end else begin
            // Only the first error since start is captured.
            if (hs_err && !err_q) begin
                err_q      <= 1'b1;
                err_line_q <= line_q;
            end
            unique case (state)
                S_IDLE: begin
                    if (start_in) begin
                        n_q        <= n_clamp;
                        line_q     <= '0;
                        pass_q     <= 1'b0;
                        err_q      <= 1'b0;
                        err_line_q <= '0;
                        state      <= (n_clamp == '0) ? S_DONE : S_PASS0;
                    end
                end
                S_PASS0, S_PASS1: begin
                    if (hs) begin
`ifdef ASM_ERROR_HALT_EN
                        if (line_err_in) begin
                            line_q <= '0;
                            state  <= S_DONE;
                        end else
`endif
                        if (last_line) begin
                            line_q <= '0;
                            if (state == S_PASS0) begin
                                pass_q <= 1'b1;
                                state  <= S_SWITCH;
                            end else begin
                                state  <= S_DONE;
                            end
                        end else begin
                            line_q <= line_q + 1'b1;
                        end
                    end
                end
                S_SWITCH: begin
                    state <= S_PASS1;
                end
                S_DONE: begin
                    pass_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign line_valid_out = in_pass;
    assign line_addr_out  = line_q;
    assign pc_out         = PC_W'({line_q, 2'b00});
    assign pass_out       = pass_q;
    assign busy_out       = (state != S_IDLE);
    assign done_out       = (state == S_DONE);
    assign error_out      = err_q;
    assign err_line_out   = err_line_q;

endmodule

// File: tb/tb_asm_pass_sequencer.sv
// Directed bench for asm_pass_sequencer: table of whole runs plus
// hand-written reset-abort and ignored-start sequences.

module tb_asm_pass_sequencer;

    localparam int NL = 256;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       start_in;
    logic [8:0] num_lines_in;
    logic       line_valid_out;
    logic       line_ready_in;
    logic       line_err_in;
    logic [7:0] line_addr_out;
    logic [9:0] pc_out;
    logic       pass_out;
    logic       busy_out;
    logic       done_out;
    logic       error_out;
    logic [7:0] err_line_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    asm_pass_sequencer #(.NUMBER_LINES(NL)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .num_lines_in   (num_lines_in),
        .line_valid_out (line_valid_out),
        .line_ready_in  (line_ready_in),
        .line_err_in    (line_err_in),
        .line_addr_out  (line_addr_out),
        .pc_out         (pc_out),
        .pass_out       (pass_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .error_out      (error_out),
        .err_line_out   (err_line_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          n;
        logic [15:0] rmask;
        int          rlen;
        int          eline;
        int          epass;
        int          exp_cyc;
        int          exp_acc;
        int          exp_err;
        int          exp_el;
        int          exp_maxpc;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, " valid"}, int'(line_valid_out), 0);
        chk({tag, " line"}, int'(line_addr_out), 0);
        chk({tag, " pc"}, int'(pc_out), 0);
        chk({tag, " pass"}, int'(pass_out), 0);
        chk({tag, " busy"}, int'(busy_out), 0);
        chk({tag, " done"}, int'(done_out), 0);
        chk({tag, " error"}, int'(error_out), 0);
        chk({tag, " err_line"}, int'(err_line_out), 0);
    endtask

    // One full run. Start is driven just after an edge; cyc counts edges
    // from there until done_out is observed.
    task automatic run(input vec_t v, input int idx);
        int  nn, cyc, acc, line, pass, ridx, maxpc;
        bit  sw, dn, r, e, seen;
        string t;
        t = $sformatf("v%0d", idx);
        nn = (v.n > NL) ? NL : v.n;
        num_lines_in = 9'(v.n);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        cyc = 1; acc = 0; line = 0; pass = 0; ridx = 0; maxpc = 0;
        sw = 1'b0; dn = (nn == 0); seen = 1'b0;
        while (cyc < 2000 && !seen) begin
            if (dn) begin
                chk({t, " done"}, int'(done_out), 1);
                chk({t, " done valid"}, int'(line_valid_out), 0);
                chk({t, " done busy"}, int'(busy_out), 1);
                seen = 1'b1;
            end else begin
                chk({t, " busy"}, int'(busy_out), 1);
                chk({t, " nodone"}, int'(done_out), 0);
                if (sw) begin
                    chk({t, " sw valid"}, int'(line_valid_out), 0);
                    chk({t, " sw pass"}, int'(pass_out), 1);
                    chk({t, " sw line"}, int'(line_addr_out), 0);
                    sw = 1'b0;
                    pass = 1;
                end else begin
                    chk({t, " valid"}, int'(line_valid_out), 1);
                    chk({t, " line"}, int'(line_addr_out), line);
                    chk({t, " pc"}, int'(pc_out), line * 4);
                    chk({t, " pass"}, int'(pass_out), pass);
                    if (int'(pc_out) > maxpc) maxpc = int'(pc_out);
                    r = v.rmask[ridx % v.rlen];
                    ridx++;
                    e = (pass == v.epass) && (line >= v.eline);
                    line_ready_in = r;
                    line_err_in = e;
                    if (r) begin
                        acc++;
`ifdef ASM_ERROR_HALT_EN
                        if (e) dn = 1'b1;
                        else
`endif
                        if (line == nn - 1) begin
                            line = 0;
                            if (pass == 0) sw = 1'b1;
                            else dn = 1'b1;
                        end else begin
                            line++;
                        end
                    end
                end
                tick();
                cyc++;
                line_ready_in = 1'b0;
                line_err_in = 1'b0;
            end
        end
        chk({t, " done seen"}, int'(seen), 1);
        chk({t, " cycles"}, cyc, v.exp_cyc);
        chk({t, " accepts"}, acc, v.exp_acc);
        chk({t, " max pc"}, maxpc, v.exp_maxpc);
        chk({t, " error"}, int'(error_out), v.exp_err);
        chk({t, " err_line"}, int'(err_line_out), v.exp_el);
        tick();
        chk({t, " post done"}, int'(done_out), 0);
        chk({t, " post busy"}, int'(busy_out), 0);
        chk({t, " post valid"}, int'(line_valid_out), 0);
        chk({t, " keep error"}, int'(error_out), v.exp_err);
        chk({t, " keep err_line"}, int'(err_line_out), v.exp_el);
    endtask

    initial begin
        int  k;
        bit  hit;
        tbl[0] = '{3, 16'h0001, 1, 999, 0, 8, 6, 0, 0, 8};
        tbl[1] = '{2, 16'b10010, 5, 999, 0, 12, 4, 0, 0, 4};
        tbl[2] = '{300, 16'h0001, 1, 999, 0, 514, 512, 0, 0, 1020};
`ifdef ASM_ERROR_HALT_EN
        tbl[3] = '{4, 16'h0001, 1, 1, 0, 3, 2, 1, 1, 4};
`else
        tbl[3] = '{4, 16'h0001, 1, 1, 0, 10, 8, 1, 1, 12};
`endif
        tbl[4] = '{0, 16'h0001, 1, 999, 0, 1, 0, 0, 0, 0};
        tbl[5] = '{3, 16'b01, 2, 2, 1, 13, 6, 1, 2, 8};
        tbl[6] = '{1, 16'h0001, 1, 999, 0, 4, 2, 0, 0, 0};

        rst_in = 1'b1;
        start_in = 1'b0;
        num_lines_in = '0;
        line_ready_in = 1'b0;
        line_err_in = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");
        rst_in = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run(tbl[i], i);
            tick();
        end

        // Reset during pass 1, line 2: abort to IDLE with no done pulse.
        num_lines_in = 9'd4;
        line_ready_in = 1'b1;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        k = 0;
        hit = 1'b0;
        while (k < 50 && !hit) begin
            if (pass_out && line_valid_out && line_addr_out == 8'd2) hit = 1'b1;
            else begin
                tick();
                k++;
            end
        end
        chk("abort reach p1l2", int'(hit), 1);
        rst_in = 1'b1;
        line_ready_in = 1'b0;
        tick();
        check_idle_zero("abort");
        rst_in = 1'b0;
        tick();
        chk("abort no done", int'(done_out), 0);
        chk("abort idle", int'(busy_out), 0);

        // Restart after abort.
        run(tbl[0], 10);
        tick();

        // Start pulsed mid-run is ignored; ready held high through start.
        num_lines_in = 9'd2;
        line_ready_in = 1'b1;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        tick();
        num_lines_in = 9'd5;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        k = 4;
        while (k < 50 && !done_out) begin
            tick();
            k++;
        end
        chk("midstart done cycle", k, 6);
        line_ready_in = 1'b0;
        tick();
        chk("midstart idle", int'(busy_out), 0);
        tick();
        chk("midstart stays idle", int'(busy_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
